// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
// Holds the digit type, FSM state encoding and the width helper used for parameter checking.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd8;
    localparam bcd_digit_t BCD_ADJ        = 4'd3;

    // Smallest w with 2^w > 10^digits - 1, i.e. enough bits for the largest decimal value.
    function automatic int bcd_bin_width(input int digits);
        longint unsigned limit;
        int              w;
        limit = 64'd1;
        w     = 0;
        for (int i = 0; i < digits; i++) begin
            limit = limit * 64'd10;
        end
        for (int k = 0; k < 63; k++) begin
            if ((64'd1 << k) < limit) begin
                w = k + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Single-digit correction step of reverse double-dabble: digits of 8 or more lose 3.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in - BCD_ADJ) : digit_in;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (shift-right / subtract-3), valid/ready on both sides.
// Optional input digit validation is built when BCD2BIN_DIGIT_CHECK_EN is defined.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BIN_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_WIDTH-1:0]  binary_out,
    output logic                  err
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH);

    generate
        if (BIN_WIDTH < bcd_bin_width(DIGITS)) begin : g_width_check
            $error("bcd_to_binary_seq: BIN_WIDTH too small for DIGITS");
        end
    endgenerate

    state_t                 state_reg;
    state_t                 state_next;
    logic [4*DIGITS-1:0]    bcd_reg;
    logic [BIN_WIDTH-1:0]   bin_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [BIN_WIDTH-1:0]   binary_out_reg;
    logic [4*DIGITS-1:0]    bcd_shifted;
    logic [4*DIGITS-1:0]    bcd_adjusted;
    logic                   accept;
    logic                   finish;

    assign accept      = (state_reg == IDLE) && in_valid;
    assign finish      = (state_reg == SHIFT) && (cnt_reg == LAST_ITER);
    assign bcd_shifted = {1'b0, bcd_reg[4*DIGITS-1:1]};

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_in  (bcd_shifted[gi*4 +: 4]),
                .digit_out (bcd_adjusted[gi*4 +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_reg == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic [DIGITS-1:0] digit_bad;
    logic [DIGITS-1:0] bad_reg;
    logic              err_reg;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign digit_bad[gi] = (bcd_in[gi*4 +: 4] > 4'd9);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_reg <= '0;
            err_reg <= 1'b0;
        end else if (accept) begin
            bad_reg <= digit_bad;
        end else if (finish) begin
            err_reg <= |bad_reg;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // The counter runs one past the last shift so the final copy happens on its own edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_reg        <= '0;
            bin_reg        <= '0;
            cnt_reg        <= '0;
            binary_out_reg <= '0;
        end else if (accept) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt_reg <= '0;
        end else if (finish) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
            binary_out_reg <= (|bad_reg) ? '0 : bin_reg;
`else
            binary_out_reg <= bin_reg;
`endif
        end else if (state_reg == SHIFT) begin
            bcd_reg <= bcd_adjusted;
            bin_reg <= {bcd_reg[0], bin_reg[BIN_WIDTH-1:1]};
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign binary_out = binary_out_reg;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized scoreboard bench for bcd_to_binary_seq; expectations come from decimal arithmetic.
// Define BCD2BIN_DIGIT_CHECK_EN to also exercise invalid-digit reporting.
module tb_bcd_to_binary_seq;

    localparam int DIGITS    = 4;
    localparam int BIN_WIDTH = 14;
    localparam int LAT       = BIN_WIDTH + 1;
    localparam int TIMEOUT   = 2000;

    typedef struct {
        int value;
        int err;
        int acc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [4*DIGITS-1:0]  bcd_in = '0;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIN_WIDTH-1:0] binary_out;
    logic                 err;

    exp_t                 q[$];
    int                   chk_cnt = 0;
    int                   pass_cnt = 0;
    int                   cyc = 0;
    bit                   seen = 0;
    bit                   ready_next = 0;
    logic [BIN_WIDTH-1:0] held;
    bit                   ready_rand = 0;
    logic                 ready_level = 1'b1;

    bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bcd_in     (bcd_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .binary_out (binary_out),
        .err        (err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: the decimal value of the digits; bad digits only matter with checking built.
    function automatic void model(input logic [4*DIGITS-1:0] v, output int val, output int e);
        int d;
        val = 0;
        e   = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'(v[i*4 +: 4]);
            if (d > 9) e = 1;
            val = val * 10 + d;
        end
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (e != 0) val = 0;
`else
        e = 0;
`endif
    endfunction

    // out_ready is driven from one place; the stimulus picks random or a fixed level.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // Monitor and scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        int   v;
        int   er;
        if (rst) begin
            q.delete();
            seen       = 0;
            ready_next = 0;
        end else begin
            if (ready_next) begin
                chk("in_ready_after_xfer", int'(in_ready), 1);
                ready_next = 0;
            end
            if (q.size() > 0) chk("in_ready_busy", int'(in_ready), 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("out_valid_unexpected", int'(out_valid), 0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc - q[0].acc, LAT);
                        seen = 1;
                        held = binary_out;
                    end else begin
                        chk("binary_out_stable", int'(binary_out), int'(held));
                    end
                    if (out_ready) begin
                        chk("binary_out", int'(binary_out), q[0].value);
                        chk("err", int'(err), q[0].err);
                        $display("xfer bcd result %0d err %0d (expected %0d/%0d)",
                                 binary_out, err, q[0].value, q[0].err);
                        void'(q.pop_front());
                        seen       = 0;
                        ready_next = 1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                model(bcd_in, v, er);
                e.value = v;
                e.err   = er;
                e.acc   = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic put(input logic [4*DIGITS-1:0] v);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        bcd_in   = v;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        logic [15:0] dir [7];
        logic [15:0] r;
        int          n;
        dir = '{16'h0000, 16'h0005, 16'h0010, 16'h0099, 16'h0100, 16'h0255, 16'h9999};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_binary_out", int'(binary_out), 0);
        chk("rst_err", int'(err), 0);

        foreach (dir[i]) begin
            put(dir[i]);
            wait_idle();
        end

        // Backpressure: result held while a new request waits.
        ready_level = 1'b0;
        put(16'h1234);
        n = 0;
        while (!out_valid && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        bcd_in   = 16'h0777;
        repeat (20) @(posedge clk);
        #1;
        ready_level = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset during SHIFT iteration 7.
        put(16'h1234);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_binary_out", int'(binary_out), 0);
        chk("midrst_err", int'(err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        put(16'h0042);
        wait_idle();

`ifdef BCD2BIN_DIGIT_CHECK_EN
        put(16'h00A5);
        wait_idle();
        put(16'h0042);
        wait_idle();
`endif

        ready_rand = 1;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < DIGITS; i++) begin
`ifdef BCD2BIN_DIGIT_CHECK_EN
                r[i*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
`else
                r[i*4 +: 4] = 4'($urandom_range(0, 9));
`endif
            end
            put(r);
        end
        wait_idle();
        ready_rand = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
